// File: rtl/hw_insert_unit.sv
// hw_insert_unit: registered immediate-insertion unit with valid/ready handshakes.
// Builds a DATA_W result from a FIELD_W immediate in UPPER, LOWER or SIGNEXT mode.
// SHIFT mode assembles a wide constant from consecutive immediates.
module hw_insert_unit #(
  parameter int DATA_W  = 10,
  parameter int FIELD_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [FIELD_W-1:0] in_imm,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               err_abort
);

  localparam int CHUNKS = DATA_W / FIELD_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHUNKS - 1);
  localparam logic [DATA_W-1:0] LOW_MASK  = {DATA_W{1'b1}} >> FIELD_W;
  localparam logic [DATA_W-1:0] HIGH_MASK = {DATA_W{1'b1}} << FIELD_W;

  localparam logic [1:0] MODE_UPPER   = 2'b00;
  localparam logic [1:0] MODE_LOWER   = 2'b01;
  localparam logic [1:0] MODE_SHIFT   = 2'b10;
  localparam logic [1:0] MODE_SIGNEXT = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                err_abort_q, err_abort_d;

  logic                accept_s;
  logic [DATA_W-1:0]   acc_base_s;
  logic [DATA_W-1:0]   shifted_s;
  logic [DATA_W-1:0]   mode_result_s;
  logic signed [FIELD_W-1:0] imm_signed_s;

  // A new beat fits whenever the output register is empty or is being drained now.
  assign in_ready     = !out_valid_q || out_ready;
  assign accept_s     = in_valid && in_ready;
  assign imm_signed_s = in_imm;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ST_ACCUM);
  assign err_abort = err_abort_q;

  // Compute the candidate result for the current beat's mode.
  always_comb begin
    // The accumulator only carries history while a SHIFT constant is being built.
    acc_base_s    = (state_q == ST_ACCUM) ? acc_q : {DATA_W{1'b0}};
    shifted_s     = (acc_base_s << FIELD_W) | DATA_W'(in_imm);
    mode_result_s = {DATA_W{1'b0}};
    case (in_mode)
      MODE_UPPER:   mode_result_s = (DATA_W'(in_imm) << (DATA_W - FIELD_W)) | (in_rs & LOW_MASK);
      MODE_LOWER:   mode_result_s = (in_rs & HIGH_MASK) | DATA_W'(in_imm);
      MODE_SIGNEXT: mode_result_s = DATA_W'(imm_signed_s);
      default:      mode_result_s = shifted_s;
    endcase
  end

  // Next-state, accumulator and output-register update for accepted beats.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    err_abort_d = 1'b0;
    if (accept_s) begin
      if (in_mode == MODE_SHIFT) begin
        // count_q is 0 in IDLE, so a single-chunk configuration also completes here.
        if (in_last || (count_q == CNT_LAST)) begin
          out_data_d  = shifted_s;
          out_valid_d = 1'b1;
          acc_d       = {DATA_W{1'b0}};
          count_d     = {CNT_W{1'b0}};
          state_d     = ST_IDLE;
        end else begin
          acc_d   = shifted_s;
          count_d = count_q + CNT_W'(1);
          state_d = ST_ACCUM;
        end
      end else begin
        // A non-SHIFT beat during accumulation throws the partial constant away.
        if (state_q == ST_ACCUM) begin
          err_abort_d = 1'b1;
        end else begin
          err_abort_d = 1'b0;
        end
        out_data_d  = mode_result_s;
        out_valid_d = 1'b1;
        acc_d       = {DATA_W{1'b0}};
        count_d     = {CNT_W{1'b0}};
        state_d     = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset discards any partial constant and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= {DATA_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_abort_q <= err_abort_d;
    end
  end

endmodule

// File: tb/tb_hw_insert_unit.sv
// Testbench for hw_insert_unit: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the insertion rules.
module tb_hw_insert_unit;

  localparam int D  = 10;
  localparam int F  = 5;
  localparam int CH = D / F;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_mode = 2'd0;
  logic [F-1:0] in_imm = '0;
  logic [D-1:0] in_rs = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [D-1:0] out_data;
  logic         busy;
  logic         err_abort;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending SHIFT immediates, unconsumed results, abort expectation.
  int pend[$];
  int exp_q[$];
  bit abort_exp = 1'b0;

  hw_insert_unit #(.DATA_W(D), .FIELD_W(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_imm(in_imm), .in_rs(in_rs), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic int mode_value(input int mode, input int imm, input int rs);
    case (mode)
      0:       return imm * (2 ** (D - F)) + rs % (2 ** (D - F));
      1:       return (rs / (2 ** F)) * (2 ** F) + imm;
      3:       return (imm >= 2 ** (F - 1)) ? imm + 2 ** D - 2 ** F : imm;
      default: return 0;
    endcase
  endfunction

  function automatic int fold_shift();
    int v = 0;
    foreach (pend[i]) v = (v * (2 ** F) + pend[i]) % (2 ** D);
    return v;
  endfunction

  // Reference model: applies each accepted beat / consumed result at the clock edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      abort_exp = 1'b0;
    end else begin
      bit mr;
      mr = (exp_q.size() == 0) || out_ready;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      abort_exp = 1'b0;
      if (in_valid && mr) begin
        if (in_mode == 2'd2) begin
          pend.push_back(int'(in_imm));
          if (in_last || pend.size() == CH) begin
            exp_q.push_back(fold_shift());
            pend.delete();
          end
        end else begin
          if (pend.size() != 0) begin
            abort_exp = 1'b1;
            pend.delete();
          end
          exp_q.push_back(mode_value(int'(in_mode), int'(in_imm), int'(in_rs)));
        end
      end
    end
  end

  // Monitor: every cycle, compare the DUT outputs with the model mid-cycle.
  initial forever begin
    @(negedge clk);
    chk("in_ready_rule", in_ready, (!out_valid) || out_ready);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("out_data_sb", out_data, exp_q[0]);
    chk("busy", busy, pend.size() != 0);
    chk("err_abort", err_abort, abort_exp);
  end

  // Present a beat and hold it until the model says it was accepted (bounded).
  task automatic send(input logic [1:0] m, input logic [F-1:0] imm, input logic [D-1:0] rs,
                      input logic last);
    bit done = 1'b0;
    in_valid = 1'b1; in_mode = m; in_imm = imm; in_rs = rs; in_last = last;
    for (int k = 0; k < 50 && !done; k++) begin
      if (exp_q.size() == 0 || out_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", done, 1'b1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 10'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_abort", err_abort, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    #20; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. UPPER
    send(2'b00, 5'b01011, 10'b0000011111, 1'b0);
    chk("upper_data", out_data, 10'b0101111111);
    chk("upper_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    chk("upper_one_cycle", out_valid, 1'b0);

    // 2. LOWER and SIGNEXT
    send(2'b01, 5'b10101, 10'b1100000000, 1'b0);
    chk("lower_data", out_data, 10'b1100010101);
    send(2'b11, 5'b10110, 10'h155, 1'b1);
    chk("sext_neg", out_data, 10'b1111110110);
    send(2'b11, 5'b01110, 10'h2AA, 1'b0);
    chk("sext_pos", out_data, 10'b0000001110);

    // 3. SHIFT accumulation and single-beat SHIFT
    send(2'b10, 5'b00011, 10'h3FF, 1'b0);
    chk("shift_b1_busy", busy, 1'b1);
    chk("shift_b1_valid", out_valid, 1'b0);
    send(2'b10, 5'b11100, 10'h000, 1'b0);
    chk("shift_b2_data", out_data, 10'b0001111100);
    chk("shift_b2_busy", busy, 1'b0);
    chk("shift_b2_valid", out_valid, 1'b1);
    send(2'b10, 5'b00111, 10'h000, 1'b1);
    chk("shift_last_data", out_data, 10'b0000000111);

    // 4. Backpressure with a queued LOWER beat
    send(2'b00, 5'b10010, 10'h0AA, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b01; in_imm = 5'b00111; in_rs = 10'h3E0; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_data", out_data, 10'h24A);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_data", out_data, 10'h3E7);
    chk("bp_second_valid", out_valid, 1'b1);

    // 5. Abort
    send(2'b10, 5'b00001, 10'h000, 1'b0);
    chk("abort_pre_busy", busy, 1'b1);
    send(2'b00, 5'b11111, 10'h000, 1'b0);
    chk("abort_pulse", err_abort, 1'b1);
    chk("abort_data", out_data, 10'b1111100000);
    chk("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("abort_pulse_end", err_abort, 1'b0);

    // 6. Reset in the middle of an accumulation
    send(2'b10, 5'b00101, 10'h000, 1'b0);
    chk("mid_busy", busy, 1'b1);
    #1; rst_n = 1'b0; #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 10'd0);
    chk("mid_rst_abort", err_abort, 1'b0);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    send(2'b10, 5'b00010, 10'h000, 1'b1);
    chk("post_rst_shift", out_data, 10'b0000000010);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_imm    = 5'($urandom_range(0, 31));
      in_rs     = 10'($urandom_range(0, 1023));
      in_last   = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
